tlc_conflict_monitor: RTL and testbench

//  Independent safety monitor on the highway/country lamp buses of the traffic light

---
 rtl/tlc_pkg.sv | 25 ++
 rtl/tlc_lamp_checker.sv | 51 +++++
 rtl/tlc_conflict_monitor.sv | 161 ++++++++++++++++
 tb/tb_tlc_conflict_monitor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light conflict monitor:
// lamp encodings, first-fault cause codes and the monitor FSM states.
package tlc_pkg;

  // Lamp codes as seen on the highway/country lamp buses
  localparam logic [1:0] RED     = 2'd0;
  localparam logic [1:0] YELLOW  = 2'd1;
  localparam logic [1:0] GREEN   = 2'd2;
  localparam logic [1:0] INVALID = 2'd3;

  // First-fault causes; lower value wins when several fire together
  localparam logic [2:0] F_NONE     = 3'd0;
  localparam logic [2:0] F_CONFLICT = 3'd1;
  localparam logic [2:0] F_INVALID  = 3'd2;
  localparam logic [2:0] F_STEP     = 3'd3;
  localparam logic [2:0] F_YELLOW   = 3'd4;
  localparam logic [2:0] F_ALLRED   = 3'd5;

  // Monitor FSM: watching normally, or latched in fault
  typedef enum logic {
    MON = 1'b0,
    FLT = 1'b1
  } mon_state_t;

endpackage

// File: rtl/tlc_lamp_checker.sv
// Per-lamp sequence checker. Keeps the previous lamp code and a saturating
// count of consecutive YELLOW samples, and flags invalid codes, illegal
// colour steps, a too-short yellow and the RED->GREEN step (used by the
// all-red clearance check in the parent).
module tlc_lamp_checker
  import tlc_pkg::*;
#(
  parameter int MIN_YELLOW = 2
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [1:0] cur,
  output logic       invalid,
  output logic       illegal_step,
  output logic       short_yellow,
  output logic       r2g
);

  localparam int DW = $clog2(MIN_YELLOW + 1);

  logic [1:0]    r_prev;
  logic [DW-1:0] r_dwell;

  // Track previous sample (invalid codes included) and the yellow dwell
  always_ff @(posedge clock) begin
    if (clear) begin
      r_prev  <= RED;
      r_dwell <= '0;
    end else begin
      r_prev <= cur;
      if (cur == YELLOW) begin
        if (r_dwell != DW'(MIN_YELLOW)) begin
          r_dwell <= r_dwell + DW'(1);
        end
      end else begin
        r_dwell <= '0;
      end
    end
  end

  // Steps touching code 3 are reported only as invalid, never as illegal
  assign invalid      = (cur == INVALID);
  assign illegal_step = (r_prev != INVALID) && (cur != INVALID) &&
                        (((r_prev == GREEN)  && (cur == RED))    ||
                         ((r_prev == RED)    && (cur == YELLOW)) ||
                         ((r_prev == YELLOW) && (cur == GREEN)));
  assign short_yellow = (r_prev == YELLOW) && (cur == RED) &&
                        (r_dwell < DW'(MIN_YELLOW));
  assign r2g          = (r_prev == RED) && (cur == GREEN);

endmodule

// File: rtl/tlc_conflict_monitor.sv
// Independent safety monitor for the traffic light controller lamp buses.
// Detects conflicting greens/yellows, invalid codes, illegal steps, short
// yellow and short all-red clearance, latches the first fault and requests
// a flashing-red override until acknowledged in a both-RED state.
// Optional build macro: ALLRED_CHECK_EN enables the all-red clearance check
// (fault code 5); without it the all-red counter is not built.
module tlc_conflict_monitor
  import tlc_pkg::*;
#(
  parameter int MIN_YELLOW = 2,
  parameter int MIN_ALLRED = 2,
  parameter int FLASH_HALF = 4
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [1:0] hwy,
  input  logic [1:0] cntry,
  input  logic       fault_ack,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash,
  output logic       flash_phase
);

  localparam int FW = $clog2(FLASH_HALF + 1);

  // Lamp 0 = highway, lamp 1 = country
  logic [1:0] w_lamp [2];
  logic [1:0] w_invalid;
  logic [1:0] w_illegal;
  logic [1:0] w_short_yel;
  logic [1:0] w_r2g;

  logic       w_conflict;
  logic       w_short_allred;
  logic [2:0] w_code;
  logic       w_viol;
  logic       w_ack_ok;

  mon_state_t r_state;
  mon_state_t w_state_next;
  logic [2:0]    r_code;
  logic          r_phase;
  logic [FW-1:0] r_flash_cnt;

  assign w_lamp[0] = hwy;
  assign w_lamp[1] = cntry;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lamp
    tlc_lamp_checker #(
      .MIN_YELLOW (MIN_YELLOW)
    ) u_chk (
      .clock        (clock),
      .clear        (clear),
      .cur          (w_lamp[gi]),
      .invalid      (w_invalid[gi]),
      .illegal_step (w_illegal[gi]),
      .short_yellow (w_short_yel[gi]),
      .r2g          (w_r2g[gi])
    );
  end

  // Both lamps showing a valid non-RED colour at once
  assign w_conflict = (hwy != RED) && (cntry != RED) &&
                      (hwy != INVALID) && (cntry != INVALID);

`ifdef ALLRED_CHECK_EN
  localparam int AW = $clog2(MIN_ALLRED + 1);
  logic [AW-1:0] r_allred;

  // Count consecutive both-RED samples; starts saturated so the first GREEN is legal
  always_ff @(posedge clock) begin
    if (clear) begin
      r_allred <= AW'(MIN_ALLRED);
    end else if ((hwy == RED) && (cntry == RED)) begin
      if (r_allred != AW'(MIN_ALLRED)) begin
        r_allred <= r_allred + AW'(1);
      end
    end else begin
      r_allred <= '0;
    end
  end

  assign w_short_allred = (|w_r2g) && (r_allred < AW'(MIN_ALLRED));
`else
  logic w_unused_r2g;
  assign w_unused_r2g   = ^w_r2g;
  assign w_short_allred = 1'b0;
`endif

  // Priority encode this cycle's violations, lowest code first
  always_comb begin
    w_code = F_NONE;
    if (w_conflict) begin
      w_code = F_CONFLICT;
    end else if (|w_invalid) begin
      w_code = F_INVALID;
    end else if (|w_illegal) begin
      w_code = F_STEP;
    end else if (|w_short_yel) begin
      w_code = F_YELLOW;
    end else if (w_short_allred) begin
      w_code = F_ALLRED;
    end
  end

  assign w_viol   = (w_code != F_NONE);
  assign w_ack_ok = fault_ack && (hwy == RED) && (cntry == RED) && !w_viol;

  // FSM state register
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= MON;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: enter fault on any violation, leave only on a clean ack
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MON:     if (w_viol)   w_state_next = FLT;
      FLT:     if (w_ack_ok) w_state_next = MON;
      default: w_state_next = MON;
    endcase
  end

  // First-fault code latch and flash divider
  always_ff @(posedge clock) begin
    if (clear) begin
      r_code      <= F_NONE;
      r_phase     <= 1'b0;
      r_flash_cnt <= '0;
    end else if ((r_state == MON) && (w_state_next == FLT)) begin
      r_code      <= w_code;
      r_phase     <= 1'b1;
      r_flash_cnt <= '0;
    end else if ((r_state == FLT) && (w_state_next == MON)) begin
      r_code      <= F_NONE;
      r_phase     <= 1'b0;
      r_flash_cnt <= '0;
    end else if (r_state == FLT) begin
      if (r_flash_cnt == FW'(FLASH_HALF - 1)) begin
        r_flash_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_flash_cnt <= r_flash_cnt + FW'(1);
      end
    end
  end

  // FSM outputs
  always_comb begin
    fault       = (r_state == FLT);
    flash       = (r_state == FLT);
    fault_code  = (r_state == FLT) ? r_code : F_NONE;
    flash_phase = (r_state == FLT) ? r_phase : 1'b0;
  end

endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// Self-checking bench for tlc_conflict_monitor: directed scenarios followed by
// randomized lamp traffic, all compared against a behavioural model that
// tracks run lengths of colours and the age of the current fault.
module tb_tlc_conflict_monitor;

  localparam int MIN_YELLOW = 2;
  localparam int MIN_ALLRED = 2;
  localparam int FLASH_HALF = 4;

  logic       clock;
  logic       clear;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic       fault_ack;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash;
  logic       flash_phase;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_fault;
  int m_code;
  int m_age;
  int m_ph, m_pc;
  int m_yh, m_yc;
  int m_ar;

  tlc_conflict_monitor #(
    .MIN_YELLOW (MIN_YELLOW),
    .MIN_ALLRED (MIN_ALLRED),
    .FLASH_HALF (FLASH_HALF)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .hwy         (hwy),
    .cntry       (cntry),
    .fault_ack   (fault_ack),
    .fault       (fault),
    .fault_code  (fault_code),
    .flash       (flash),
    .flash_phase (flash_phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Colour that legally follows p in the R->G->Y->R cycle
  function automatic int succ(int p);
    case (p)
      0:       return 2;
      2:       return 1;
      1:       return 0;
      default: return p;
    endcase
  endfunction

  function automatic bit step_legal(int p, int c);
    if (p == 3 || c == 3) return 1'b1;
    return (c == p) || (c == succ(p));
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_edge();
    int h, c, code;
    h = int'(hwy);
    c = int'(cntry);
    if (clear) begin
      m_fault = 0; m_code = 0; m_age = 0;
      m_ph = 0; m_pc = 0; m_yh = 0; m_yc = 0;
      m_ar = MIN_ALLRED;
      return;
    end
    code = 0;
    if (code == 0 && h != 0 && c != 0 && h != 3 && c != 3) code = 1;
    if (code == 0 && (h == 3 || c == 3)) code = 2;
    if (code == 0 && (!step_legal(m_ph, h) || !step_legal(m_pc, c))) code = 3;
    if (code == 0 && ((m_ph == 1 && h == 0 && m_yh < MIN_YELLOW) ||
                      (m_pc == 1 && c == 0 && m_yc < MIN_YELLOW))) code = 4;
`ifdef ALLRED_CHECK_EN
    if (code == 0 && ((m_ph == 0 && h == 2) || (m_pc == 0 && c == 2)) &&
        m_ar < MIN_ALLRED) code = 5;
`endif
    if (!m_fault) begin
      if (code != 0) begin
        m_fault = 1; m_code = code; m_age = 0;
      end
    end else if (fault_ack && h == 0 && c == 0 && code == 0) begin
      m_fault = 0; m_code = 0; m_age = 0;
    end else begin
      m_age++;
    end
    m_yh = (h == 1) ? m_yh + 1 : 0;
    m_yc = (c == 1) ? m_yc + 1 : 0;
    m_ar = (h == 0 && c == 0) ? m_ar + 1 : 0;
    m_ph = h;
    m_pc = c;
  endtask

  task automatic check_model();
    bit exp_phase;
    exp_phase = m_fault && (((m_age / FLASH_HALF) % 2) == 0);
    check("fault",       32'(fault),       32'(m_fault));
    check("fault_code",  32'(fault_code),  32'(m_code));
    check("flash",       32'(flash),       32'(m_fault));
    check("flash_phase", 32'(flash_phase), 32'(exp_phase));
  endtask

  // Drive one sample, clock it, then compare DUT with the model away from the edge
  task automatic step(logic [1:0] h, logic [1:0] c, logic a);
    hwy = h; cntry = c; fault_ack = a;
    @(posedge clock);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    int rh, rc, r;
    clear = 1'b1; hwy = 2'd0; cntry = 2'd0; fault_ack = 1'b0;
    step(2'd0, 2'd0, 1'b0);
    step(2'd2, 2'd1, 1'b0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_code",  32'(fault_code), 32'd0);
    check("rst_flash", 32'(flash), 32'd0);
    check("rst_phase", 32'(flash_phase), 32'd0);
    clear = 1'b0;

    // Legal full cycle
    repeat (5) step(2'd2, 2'd0, 1'b0);
    repeat (2) step(2'd1, 2'd0, 1'b0);
    repeat (2) step(2'd0, 2'd0, 1'b0);
    repeat (3) step(2'd0, 2'd2, 1'b0);
    repeat (2) step(2'd0, 2'd1, 1'b0);
    repeat (2) step(2'd0, 2'd0, 1'b0);
    step(2'd2, 2'd0, 1'b0);
    check("legal_fault", 32'(fault), 32'd0);

    // Conflict, then flash phase pattern
    step(2'd2, 2'd1, 1'b0);
    check("conf_fault", 32'(fault), 32'd1);
    check("conf_code",  32'(fault_code), 32'd1);
    check("conf_flash", 32'(flash), 32'd1);
    check("conf_phase0", 32'(flash_phase), 32'd1);
    for (int k = 1; k < 8; k++) begin
      step(2'd0, 2'd0, 1'b0);
      check("flash_phase_seq", 32'(flash_phase), (k < FLASH_HALF) ? 32'd1 : 32'd0);
    end

    // Ack while hwy GREEN is ignored; clean ack in R/R clears
    step(2'd2, 2'd0, 1'b1);
    check("ack_green_fault", 32'(fault), 32'd1);
    check("ack_green_code",  32'(fault_code), 32'd1);
    repeat (2) step(2'd1, 2'd0, 1'b0);
    step(2'd0, 2'd0, 1'b1);
    check("ack_fault", 32'(fault), 32'd0);
    check("ack_code",  32'(fault_code), 32'd0);
    check("ack_flash", 32'(flash), 32'd0);
    check("ack_phase", 32'(flash_phase), 32'd0);

    // Short yellow on highway
    step(2'd0, 2'd0, 1'b0);
    step(2'd2, 2'd0, 1'b0);
    step(2'd1, 2'd0, 1'b0);
    step(2'd0, 2'd0, 1'b0);
    check("short_yel_code", 32'(fault_code), 32'd4);
    step(2'd0, 2'd0, 1'b1);
    check("short_yel_ack", 32'(fault), 32'd0);

    // Country G->R directly
    step(2'd0, 2'd2, 1'b0);
    step(2'd0, 2'd0, 1'b0);
    check("g2r_code", 32'(fault_code), 32'd3);
    step(2'd0, 2'd0, 1'b1);
    check("g2r_ack", 32'(fault), 32'd0);

    // Invalid highway beats same-cycle illegal country step
    step(2'd0, 2'd2, 1'b0);
    step(2'd3, 2'd0, 1'b0);
    check("inv_code", 32'(fault_code), 32'd2);
    step(2'd0, 2'd0, 1'b1);
    check("inv_ack", 32'(fault), 32'd0);

    // Zero all-red clearance
    step(2'd0, 2'd0, 1'b0);
    step(2'd0, 2'd2, 1'b0);
    repeat (2) step(2'd0, 2'd1, 1'b0);
    step(2'd2, 2'd0, 1'b0);
`ifdef ALLRED_CHECK_EN
    check("allred_code", 32'(fault_code), 32'd5);
`else
    check("allred_code", 32'(fault_code), 32'd0);
`endif
    repeat (2) step(2'd1, 2'd0, 1'b0);
    step(2'd0, 2'd0, 1'b1);
    check("allred_ack", 32'(fault), 32'd0);

    // Violation on the ack cycle keeps the original code
    step(2'd2, 2'd2, 1'b0);
    check("ackviol_enter", 32'(fault_code), 32'd1);
    step(2'd0, 2'd0, 1'b1);
    check("ackviol_fault", 32'(fault), 32'd1);
    check("ackviol_code",  32'(fault_code), 32'd1);
    step(2'd0, 2'd0, 1'b1);
    check("ackviol_clear", 32'(fault), 32'd0);

    // Clear during fault
    step(2'd2, 2'd1, 1'b0);
    check("clr_pre_fault", 32'(fault), 32'd1);
    clear = 1'b1;
    step(2'd2, 2'd1, 1'b0);
    check("clr_fault", 32'(fault), 32'd0);
    check("clr_code",  32'(fault_code), 32'd0);
    check("clr_flash", 32'(flash), 32'd0);
    check("clr_phase", 32'(flash_phase), 32'd0);
    clear = 1'b0;
    step(2'd2, 2'd0, 1'b0);
    check("post_clr_green", 32'(fault), 32'd0);

    // Randomized traffic biased towards legal sequences and recoveries
    rh = 2; rc = 0;
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        step(2'(rh), 2'(rc), ($urandom_range(0, 3) == 0));
      end else if (r < 7) begin
        if ($urandom_range(0, 1) == 1) rh = succ(rh);
        else rc = succ(rc);
        step(2'(rh), 2'(rc), 1'b0);
      end else if (r < 8) begin
        rh = $urandom_range(0, 3);
        rc = $urandom_range(0, 3);
        step(2'(rh), 2'(rc), 1'b0);
      end else begin
        rh = 0; rc = 0;
        step(2'd0, 2'd0, 1'b1);
      end
      if (i == 400) begin
        clear = 1'b1;
        step(2'(rh), 2'(rc), 1'b0);
        clear = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
